// File: rtl/blake2_pkg.sv
// rtl/blake2_pkg.sv - shared blake2 width defaults and feeder state encoding
// Purpose : widths common to the blake2 core and its byte-load front end.
// Contents: W/BB defaults, kk/nn and byte-index widths, feeder FSM states.
package blake2_pkg;

  localparam int W_DEF    = 64;
  localparam int BB_DEF   = W_DEF * 2;
  localparam int KNW_DEF  = $clog2(W_DEF + 1);
  localparam int IDXW_DEF = $clog2(BB_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_GAP  = 2'd2
  } e_feed_fsm;

endpackage

// File: rtl/blake2_msg_feeder.sv
// rtl/blake2_msg_feeder.sv - key/message byte feeder for the blake2 core load port
// Purpose : turns a start command plus key and message byte streams into
//           zero-padded blocks, one byte per cycle, paced by the core's ready.
// Ports   : clk, reset (sync, active-high)
//           start_i, kk_i, nn_i, len_i     command; sampled only when idle
//           key_v_i/key_i/key_rdy_o        key byte stream
//           msg_v_i/msg_i/msg_rdy_o        message byte stream
//           core_ready_i                   core accepts bytes
//           data_v_o, data_idx_o, data_o   registered byte to core
//           block_first_o, block_last_o    per-block flags
//           kk_o, nn_o, ll_o               latched config and total byte count
//           busy_o, cfg_err_o              status
module blake2_msg_feeder
  import blake2_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int BB   = W * 2,
  parameter int KNW  = $clog2(W + 1),
  parameter int IDXW = $clog2(BB)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [KNW-1:0]  kk_i,
  input  logic [KNW-1:0]  nn_i,
  input  logic [BB-1:0]   len_i,
  input  logic            key_v_i,
  input  logic [7:0]      key_i,
  output logic            key_rdy_o,
  input  logic            msg_v_i,
  input  logic [7:0]      msg_i,
  output logic            msg_rdy_o,
  input  logic            core_ready_i,
  output logic            data_v_o,
  output logic [IDXW-1:0] data_idx_o,
  output logic [7:0]      data_o,
  output logic            block_first_o,
  output logic            block_last_o,
  output logic [KNW-1:0]  kk_o,
  output logic [KNW-1:0]  nn_o,
  output logic [BB-1:0]   ll_o,
  output logic            busy_o,
  output logic            cfg_err_o
);

  localparam int              CW      = KNW + IDXW;
  localparam logic [BB-1:0]   BB_LEN  = BB'(BB);
  localparam logic [KNW-1:0]  W_K     = KNW'(W);
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(BB - 1);

  e_feed_fsm       state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [BB-1:0]   rem_q, rem_d;
  logic            key_blk_q, key_blk_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic            data_v_q, data_v_d;
  logic [7:0]      data_q, data_d;
  logic [IDXW-1:0] data_idx_q, data_idx_d;
  logic [KNW-1:0]  kk_q, kk_d;
  logic [KNW-1:0]  nn_q, nn_d;
  logic [BB-1:0]   ll_q, ll_d;
  logic            busy_q, busy_d;
  logic            cfg_err_q, cfg_err_d;

  logic            cfg_ok;
  logic            in_key;
  logic            in_msg;
  logic            src_avail;
  logic [7:0]      src_byte;
  logic            take;

  // Source selection by position in the block; padding bytes are always ready.
  always_comb begin
    cfg_ok    = (nn_i != '0) && (nn_i <= W_K) && (kk_i <= W_K);
    in_key    = key_blk_q && (CW'(idx_q) < CW'(kk_q));
    in_msg    = !key_blk_q && (rem_q != '0);
    src_byte  = 8'h00;
    src_avail = 1'b1;
    if (in_key) begin
      src_byte  = key_i;
      src_avail = key_v_i;
    end else if (in_msg) begin
      src_byte  = msg_i;
      src_avail = msg_v_i;
    end
    take = (state_q == S_LOAD) && core_ready_i && src_avail;
  end

  assign key_rdy_o = take && in_key;
  assign msg_rdy_o = take && in_msg;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    key_blk_d  = key_blk_q;
    first_d    = first_q;
    last_d     = last_q;
    data_v_d   = 1'b0;
    data_d     = data_q;
    data_idx_d = data_idx_q;
    kk_d       = kk_q;
    nn_d       = nn_q;
    ll_d       = ll_q;
    busy_d     = busy_q;
    cfg_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            state_d   = S_LOAD;
            busy_d    = 1'b1;
            kk_d      = kk_i;
            nn_d      = nn_i;
            ll_d      = len_i + ((kk_i != '0) ? BB_LEN : '0);
            rem_d     = len_i;
            idx_d     = '0;
            key_blk_d = (kk_i != '0);
            first_d   = 1'b1;
            // Key block is last only for an empty message; otherwise the
            // first message block (or the lone zero block) is last if it
            // holds everything.
            last_d    = (kk_i != '0) ? (len_i == '0) : (len_i <= BB_LEN);
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (take) begin
          data_v_d   = 1'b1;
          data_d     = src_byte;
          data_idx_d = idx_q;
          idx_d      = idx_q + 1'b1;
          if (in_msg) begin
            rem_d = rem_q - 1'b1;
          end
          if (idx_q == IDX_MAX) begin
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        // One dead cycle: the core's ready lags by a cycle, so it is not
        // trusted here.
        idx_d = '0;
        if (last_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d   = S_LOAD;
          key_blk_d = 1'b0;
          first_d   = 1'b0;
          last_d    = (rem_q <= BB_LEN);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rem_q      <= '0;
      key_blk_q  <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      data_v_q   <= 1'b0;
      data_q     <= '0;
      data_idx_q <= '0;
      kk_q       <= '0;
      nn_q       <= '0;
      ll_q       <= '0;
      busy_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      key_blk_q  <= key_blk_d;
      first_q    <= first_d;
      last_q     <= last_d;
      data_v_q   <= data_v_d;
      data_q     <= data_d;
      data_idx_q <= data_idx_d;
      kk_q       <= kk_d;
      nn_q       <= nn_d;
      ll_q       <= ll_d;
      busy_q     <= busy_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign data_v_o      = data_v_q;
  assign data_idx_o    = data_idx_q;
  assign data_o        = data_q;
  assign block_first_o = first_q;
  assign block_last_o  = last_q;
  assign kk_o          = kk_q;
  assign nn_o          = nn_q;
  assign ll_o          = ll_q;
  assign busy_o        = busy_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_blake2_msg_feeder.sv
// tb/tb_blake2_msg_feeder.sv - scoreboard bench for blake2_msg_feeder
module tb_blake2_msg_feeder;

  localparam int BB = 128;

  typedef struct packed {
    logic [7:0] d;
    logic [6:0] idx;
    logic       first;
    logic       last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [6:0]   kk_i, nn_i;
  logic [127:0] len_i;
  logic         key_v_i, msg_v_i;
  logic [7:0]   key_i, msg_i;
  logic         key_rdy_o, msg_rdy_o;
  logic         core_ready_i;
  logic         data_v_o;
  logic [6:0]   data_idx_o;
  logic [7:0]   data_o;
  logic         block_first_o, block_last_o;
  logic [6:0]   kk_o, nn_o;
  logic [127:0] ll_o;
  logic         busy_o, cfg_err_o;

  exp_t       sb[$];
  logic [7:0] kq[$];
  logic [7:0] mq[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         msg_cnt = 0;
  bit         msg_toggle = 1'b0;

  blake2_msg_feeder dut (
    .clk(clk), .reset(reset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i),
    .len_i(len_i), .key_v_i(key_v_i), .key_i(key_i), .key_rdy_o(key_rdy_o),
    .msg_v_i(msg_v_i), .msg_i(msg_i), .msg_rdy_o(msg_rdy_o),
    .core_ready_i(core_ready_i), .data_v_o(data_v_o), .data_idx_o(data_idx_o),
    .data_o(data_o), .block_first_o(block_first_o), .block_last_o(block_last_o),
    .kk_o(kk_o), .nn_o(nn_o), .ll_o(ll_o), .busy_o(busy_o), .cfg_err_o(cfg_err_o)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every byte the DUT presents is popped and compared.
  exp_t mon_e;
  logic cr_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (data_v_o) begin
      chk("issued_with_ready", cr_prev, 1'b1);
      if (sb.size() == 0) begin
        chk("unexpected_byte", data_v_o, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("data", data_o, mon_e.d);
        chk("idx", data_idx_o, mon_e.idx);
        chk("first", block_first_o, mon_e.first);
        chk("last", block_last_o, mon_e.last);
      end
    end
    cr_prev = core_ready_i;
  end

  // Byte sources: pop a byte when the DUT took it at the preceding edge.
  bit k_take, m_take, tog_phase;
  initial begin
    key_v_i = 1'b0; key_i = 8'h00; msg_v_i = 1'b0; msg_i = 8'h00;
    tog_phase = 1'b0;
    forever begin
      @(negedge clk);
      k_take = key_rdy_o;
      m_take = msg_rdy_o;
      @(posedge clk);
      #1;
      if (k_take && kq.size() > 0) kq.delete(0);
      if (m_take) begin
        msg_cnt++;
        if (mq.size() > 0) mq.delete(0);
      end
      tog_phase = ~tog_phase;
      key_v_i = (kq.size() > 0);
      key_i   = (kq.size() > 0) ? kq[0] : 8'h00;
      msg_v_i = (mq.size() > 0) && (!msg_toggle || tog_phase);
      msg_i   = (mq.size() > 0) ? mq[0] : 8'h00;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Expected block plan; key byte j = kb+j, message byte i = mb+i.
  // One spare key byte and one spare message byte are queued beyond kk/len.
  task automatic plan(input int kk, input int len, input logic [7:0] kb, input logic [7:0] mb);
    int nkey, nblk, m;
    exp_t e;
    nkey = (kk != 0) ? 1 : 0;
    nblk = nkey + (len + BB - 1) / BB;
    if (nblk == 0) nblk = 1;
    for (int j = 0; j < kk + 1; j++) kq.push_back(8'(kb + j));
    for (int i = 0; i < len + 1; i++) mq.push_back(8'(mb + i));
    for (int b = 0; b < nblk; b++) begin
      for (int p = 0; p < BB; p++) begin
        e.idx   = 7'(p);
        e.first = (b == 0);
        e.last  = (b == nblk - 1);
        if (b < nkey) begin
          e.d = (p < kk) ? 8'(kb + p) : 8'h00;
        end else begin
          m   = (b - nkey) * BB + p;
          e.d = (m < len) ? 8'(mb + m) : 8'h00;
        end
        sb.push_back(e);
      end
    end
    msg_cnt = 0;
  endtask

  task automatic start(input int kk, input int nn, input int len, input int ll_exp);
    step();
    start_i = 1'b1; kk_i = 7'(kk); nn_i = 7'(nn); len_i = 128'(len);
    step();
    start_i = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy_o, 1'b1);
    chk("cfg_err_on_good_start", cfg_err_o, 1'b0);
    chk("kk_o", kk_o, 128'(kk));
    chk("nn_o", nn_o, 128'(nn));
    chk("ll_o", ll_o, 128'(ll_exp));
  endtask

  task automatic wait_idx(input int t, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (data_v_o && data_idx_o == 7'(t)) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_idx", found, 1'b1);
    step();
  endtask

  task automatic wait_done(input int budget, input int ll_exp, input int msgs);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy_o && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("stream_done", done, 1'b1);
    chk("ll_held", ll_o, 128'(ll_exp));
    step();
    chk("msg_take_count", msg_cnt, msgs);
    chk("spare_msg_untouched", mq.size(), 1);
    chk("spare_key_untouched", kq.size(), 1);
    mq.delete();
    kq.delete();
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; kk_i = '0; nn_i = '0; len_i = '0;
    core_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_v", data_v_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ll", ll_o, 128'd0);
    chk("rst_cfg_err", cfg_err_o, 1'b0);
    chk("rst_first", block_first_o, 1'b0);
    step();
    reset = 1'b0;
    core_ready_i = 1'b1;

    // 1: empty message, no key -> one zero block
    plan(0, 0, 8'h00, 8'h00);
    start(0, 64, 0, 0);
    wait_done(600, 0, 0);

    // 2: "abc"
    plan(0, 3, 8'h00, 8'h61);
    start(0, 64, 3, 3);
    wait_done(600, 3, 3);

    // 3: 4-byte key, 200-byte message -> 3 blocks, ll = 200 + 128
    plan(4, 200, 8'hA0, 8'h00);
    start(4, 64, 200, 328);
    wait_done(1500, 328, 200);

    // 4: core stalls mid-block and after the gap; start while busy ignored
    plan(0, 256, 8'h00, 8'h10);
    start(0, 64, 256, 256);
    wait_idx(40, 300);
    core_ready_i = 1'b0;
    start_i = 1'b1; nn_i = 7'd0;
    step();
    start_i = 1'b0;
    @(negedge clk);
    chk("start_while_busy_no_err", cfg_err_o, 1'b0);
    chk("busy_while_stalled", busy_o, 1'b1);
    chk("no_byte_while_stalled", data_v_o, 1'b0);
    repeat (4) step();
    core_ready_i = 1'b1;
    wait_idx(127, 300);
    core_ready_i = 1'b0;
    repeat (20) step();
    core_ready_i = 1'b1;
    wait_done(1000, 256, 256);

    // 5: message source drops valid every other cycle
    msg_toggle = 1'b1;
    plan(0, 130, 8'h00, 8'h20);
    start(0, 64, 130, 130);
    wait_done(1500, 130, 130);
    msg_toggle = 1'b0;

    // 6: reset mid-block, then a fresh keyed stream
    plan(0, 300, 8'h00, 8'h40);
    start(0, 64, 300, 300);
    wait_idx(50, 300);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete(); mq.delete(); kq.delete();
    @(negedge clk);
    chk("rst_mid_data_v", data_v_o, 1'b0);
    chk("rst_mid_idx", data_idx_o, 7'd0);
    chk("rst_mid_data", data_o, 8'h00);
    chk("rst_mid_first", block_first_o, 1'b0);
    chk("rst_mid_last", block_last_o, 1'b0);
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_ll", ll_o, 128'd0);
    chk("rst_mid_kk", kk_o, 7'd0);
    repeat (3) step();
    plan(2, 5, 8'h11, 8'h70);
    start(2, 32, 5, 133);
    wait_done(800, 133, 5);

    // rejected configurations: nn = 0, kk > W
    start_i = 1'b1; kk_i = 7'd0; nn_i = 7'd0; len_i = 128'd7;
    step();
    start_i = 1'b0;
    @(negedge clk);
    chk("cfg_err_nn0", cfg_err_o, 1'b1);
    chk("cfg_err_nn0_busy", busy_o, 1'b0);
    @(negedge clk);
    chk("cfg_err_one_cycle", cfg_err_o, 1'b0);
    step();
    start_i = 1'b1; kk_i = 7'd65; nn_i = 7'd64;
    step();
    start_i = 1'b0;
    @(negedge clk);
    chk("cfg_err_kk65", cfg_err_o, 1'b1);
    chk("cfg_err_kk65_busy", busy_o, 1'b0);
    repeat (5) @(negedge clk);
    chk("no_stray_bytes", sb.size(), 0);
    chk("idle_busy", busy_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
